div_dispatch: RTL and testbench
===============================

// Module: div_dispatch
// PURPOSE
//   Request front-end for the iterative divider in the GPU datapath (perspective/attribute divides).
//   Buffers tagged divide requests in a small FIFO and issues them one at a time via div_start.
//   On div_finished it captures the quotient and returns it in order with its tag over valid/ready.
// PARAMETERS
//   WIDTH  32  operand/quotient width; must match the divider's WIDTH
//   TAG_W  4   request tag width, returned unchanged with the result
//   DEPTH  4   request FIFO entries; power of two, >=2
// PORTS
//   clk              in   1       clock, all logic on rising edge
//   rst              in   1       synchronous, active-high reset
//   req_valid        in   1       request offered
//   req_ready        out  1       FIFO can accept (= !full)
//   req_num          in   WIDTH   numerator
//   req_den          in   WIDTH   denominator
//   req_tag          in   TAG_W   caller tag
//   div_start        out  1       one-cycle pulse to divider
//   div_numerator    out  WIDTH   held stable ISSUE..WAIT
//   div_denominator  out  WIDTH   held stable ISSUE..WAIT
//   div_quotient     in   WIDTH   divider result, valid with div_finished
//   div_finished     in   1       divider done
//   rsp_valid        out  1       result available
//   rsp_ready        in   1       consumer accepts
//   rsp_quotient     out  WIDTH   result
//   rsp_tag          out  TAG_W   tag of the result
//   rsp_dbz          out  1       divide-by-zero flag (0 when macro off)
//   busy             out  1       state!=IDLE or FIFO non-empty
// BEHAVIOUR
//   Reset: state IDLE, FIFO empty, all outputs 0 except req_ready=1; the in-flight op is abandoned.
//   FIFO: push on req_valid&&req_ready. Pointers carry an extra wrap bit; full/empty derive from it.
//   No push while full; pop only from IDLE when non-empty.
//   FSM: IDLE -> ISSUE when !empty (pop; latch num/den/tag into div_* regs and tag reg).
//        ISSUE: div_start=1 for exactly this cycle -> WAIT unconditionally.
//        WAIT: on div_finished latch div_quotient into rsp_quotient, rsp_valid<=1 -> HOLD.
//        HOLD: rsp_valid held; outputs stable until rsp_ready; on handshake rsp_valid<=0 -> IDLE.
//   div_finished outside WAIT is ignored (covers late finish after reset).
//   Latency: request accepted at edge E -> div_start high in cycle E+2.
//   div_finished in cycle F -> rsp_valid high from F+1.
//   Results are strictly in request order; one division in flight at a time.
//   A push and the IDLE pop on the same edge are both honoured; count is unchanged.
// CONFIGURATION
//   DIV_ZERO_BYPASS_EN defined: IDLE pop with den==0 goes straight to HOLD, no div_start.
//     rsp_quotient={WIDTH{1'b1}}, rsp_dbz=1. Latency: push edge E -> rsp_valid at E+2.
//   Not defined: rsp_dbz tied 0; den==0 issued to the divider like any other request.
// STRUCTURE
//   gpu_div_pkg: div_state_t enum {IDLE,ISSUE,WAIT,HOLD}.
//     div_req_t struct {num, den, tag} (parameterised via package localparams for WIDTH/TAG_W).
//   Sub-module div_req_fifo: synchronous FIFO of div_req_t, ports push/pop/full/empty/dout.
//   The FSM and the result register live in div_dispatch.
// TESTING (bench models divider: finished 32 cycles after start, quotient=num/den)
//   1 100/7 tag 3 -> one div_start pulse 2 cycles after accept; rsp 14, tag 3, dbz 0.
//   2 Six back-to-back pushes, rsp_ready=1 -> req_ready low after 5th accept.
//     Responses tags 0..5 in order; exactly 6 div_start pulses.
//   3 rsp_ready=0 for 10 cycles in HOLD -> rsp_valid, quotient, tag stable; no div_start.
//   4 5/0: with macro -> no div_start, rsp 0xFFFFFFFF, dbz=1 at E+2.
//     Without macro -> div_start issued, dbz=0.
//   5 rst in WAIT, then div_finished pulse -> rsp_valid stays 0, busy=0, req_ready=1.
//   6 20 streamed requests, random rsp_ready -> pointers wrap; all 20 correct, in order.

Source files
------------

// File: rtl/gpu_div_pkg.sv
// Shared types for the GPU divider dispatch front-end: FSM states and the queued request payload.
package gpu_div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_TAG_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } div_state_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] num;
    logic [DIV_WIDTH-1:0] den;
    logic [DIV_TAG_W-1:0] tag;
  } div_req_t;

endpackage

// File: rtl/div_req_fifo.sv
// Synchronous request FIFO with show-ahead output; pointers carry an extra wrap bit for full/empty.
module div_req_fifo
  import gpu_div_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  div_req_t din,
  output div_req_t dout,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  div_req_t   mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        do_push;
  logic        do_pop;

  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = (wr_q == rd_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/div_dispatch.sv
// Front-end for the iterative divider: queues tagged requests, issues one at a time, returns results in order.
// Optional macro DIV_ZERO_BYPASS_EN answers den==0 requests locally (all-ones quotient, rsp_dbz=1).
module div_dispatch
  import gpu_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned TAG_W = DIV_TAG_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_num,
  input  logic [WIDTH-1:0] req_den,
  input  logic [TAG_W-1:0] req_tag,
  output logic             div_start,
  output logic [WIDTH-1:0] div_numerator,
  output logic [WIDTH-1:0] div_denominator,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic             div_finished,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_dbz,
  output logic             busy
);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             start_q, start_d;
  logic             rsp_valid_q, rsp_valid_d;

  div_req_t         fifo_din;
  div_req_t         fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  // Struct widths come from the package, so WIDTH/TAG_W must match DIV_WIDTH/DIV_TAG_W.
  assign fifo_din = '{num: req_num, den: req_den, tag: req_tag};

  div_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (req_valid),
    .pop  (fifo_pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

`ifdef DIV_ZERO_BYPASS_EN
  logic dbz_q, dbz_d;
`endif

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    den_d       = den_q;
    tag_d       = tag_q;
    quot_d      = quot_q;
    rsp_valid_d = rsp_valid_q;
    start_d     = 1'b0;
    fifo_pop    = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
    dbz_d       = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          num_d    = fifo_dout.num;
          den_d    = fifo_dout.den;
          tag_d    = fifo_dout.tag;
`ifdef DIV_ZERO_BYPASS_EN
          if (fifo_dout.den == '0) begin
            state_d     = HOLD;
            quot_d      = '1;
            dbz_d       = 1'b1;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = ISSUE;
            start_d = 1'b1;
          end
`else
          state_d = ISSUE;
          start_d = 1'b1;
`endif
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Finish is only honoured here, so a stale pulse after reset is dropped.
        if (div_finished) begin
          quot_d      = div_quotient;
          rsp_valid_d = 1'b1;
          state_d     = HOLD;
`ifdef DIV_ZERO_BYPASS_EN
          dbz_d       = 1'b0;
`endif
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      num_q       <= '0;
      den_q       <= '0;
      tag_q       <= '0;
      quot_q      <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      den_q       <= den_d;
      tag_q       <= tag_d;
      quot_q      <= quot_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef DIV_ZERO_BYPASS_EN
  always_ff @(posedge clk) begin
    if (rst) dbz_q <= 1'b0;
    else     dbz_q <= dbz_d;
  end
  assign rsp_dbz = dbz_q;
`else
  assign rsp_dbz = 1'b0;
`endif

  assign req_ready       = !fifo_full;
  assign div_start       = start_q;
  assign div_numerator   = num_q;
  assign div_denominator = den_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_quotient    = quot_q;
  assign rsp_tag         = tag_q;
  assign busy            = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_div_dispatch.sv
// Self-checking bench for div_dispatch with a 32-cycle divider model; honours DIV_ZERO_BYPASS_EN.
module tb_div_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_num;
  logic [31:0] req_den;
  logic [3:0]  req_tag;
  logic        div_start;
  logic [31:0] div_numerator;
  logic [31:0] div_denominator;
  logic [31:0] div_quotient;
  logic        div_finished;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_quotient;
  logic [3:0]  rsp_tag;
  logic        rsp_dbz;
  logic        busy;

  always #5 clk = ~clk;

  div_dispatch #(.WIDTH(32), .TAG_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_num(req_num), .req_den(req_den), .req_tag(req_tag),
    .div_start(div_start), .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_quotient(div_quotient), .div_finished(div_finished),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_tag(rsp_tag), .rsp_dbz(rsp_dbz),
    .busy(busy)
  );

  typedef struct {
    logic [31:0] q;
    logic [3:0]  tag;
    logic        dbz;
  } rsp_t;

  typedef struct {
    logic [31:0] num;
    logic [31:0] den;
    logic [3:0]  tag;
    logic [31:0] q;
  } vec_t;

  rsp_t exp_q[$];
  rsp_t got_q[$];
  int   total = 0;
  int   bad = 0;
  int   start_cnt = 0;
  int   fin_cnt = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never

  // Divider model: one-cycle finish 32 cycles after start, quotient = num/den (all ones for den 0).
  initial begin
    int unsigned cnt;
    logic [31:0] mq;
    cnt = 0;
    mq = '0;
    div_finished = 1'b0;
    div_quotient = '0;
    forever begin
      @(negedge clk);
      div_finished = 1'b0;
      if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          div_finished = 1'b1;
          div_quotient = mq;
          fin_cnt++;
        end
      end
      if (div_start) begin
        mq  = (div_denominator == 0) ? 32'hFFFF_FFFF : div_numerator / div_denominator;
        cnt = 32;
      end
    end
  end

  // Consumer: sets rsp_ready for the coming edge, then records the handshake that edge will make.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
      if (div_start) start_cnt++;
      if (rsp_valid && rsp_ready && !rst)
        got_q.push_back('{q: rsp_quotient, tag: rsp_tag, dbz: rsp_dbz});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with req_valid still high.
  task automatic push(input logic [31:0] n, input logic [31:0] d, input logic [3:0] t);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1;
    req_num = n;
    req_den = d;
    req_tag = t;
    for (int k = 0; k < 500; k++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("push_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_rsps(input int n);
    for (int k = 0; k < 3000 && got_q.size() < n; k++) @(negedge clk);
    if (got_q.size() < n) chk("rsp_timeout", 32'(got_q.size()), 32'(n));
  endtask

  task automatic compare_all(input string nm);
    rsp_t e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        chk({nm, "_missing"}, 32'd0, 32'd1);
        break;
      end
      g = got_q.pop_front();
      chk({nm, "_quot"}, g.q, e.q);
      chk({nm, "_tag"}, 32'(g.tag), 32'(e.tag));
      chk({nm, "_dbz"}, 32'(g.dbz), 32'(e.dbz));
    end
    chk({nm, "_extra"}, 32'(got_q.size()), 32'd0);
    got_q.delete();
  endtask

  initial begin
    vec_t vecs[6];
    int   s0;
    int   hi_cnt;
    int   f0;
    logic [31:0] n, d;

    vecs[0] = '{num: 32'd100,         den: 32'd7,           tag: 4'd3,  q: 32'd14};
    vecs[1] = '{num: 32'hFFFF_FFFF,   den: 32'd1,           tag: 4'd15, q: 32'hFFFF_FFFF};
    vecs[2] = '{num: 32'd1,           den: 32'hFFFF_FFFF,   tag: 4'd1,  q: 32'd0};
    vecs[3] = '{num: 32'd12345678,    den: 32'd3,           tag: 4'd7,  q: 32'd4115226};
    vecs[4] = '{num: 32'd7,           den: 32'd7,           tag: 4'd0,  q: 32'd1};
    vecs[5] = '{num: 32'd0,           den: 32'd5,           tag: 4'd12, q: 32'd0};

    rst = 1'b1;
    req_valid = 1'b0;
    req_num = '0;
    req_den = '0;
    req_tag = '0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_quot", rsp_quotient, 32'd0);
    chk("rst_dbz", 32'(rsp_dbz), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request latency: div_start only in the second cycle after the accepting edge.
    push(32'd100, 32'd7, 4'd3);
    req_valid = 1'b0;
    chk("t1_start_e1", 32'(div_start), 32'd0);
    @(negedge clk);
    chk("t1_start_e2", 32'(div_start), 32'd1);
    @(negedge clk);
    chk("t1_start_e3", 32'(div_start), 32'd0);
    exp_q.push_back('{q: 32'd14, tag: 4'd3, dbz: 1'b0});
    wait_rsps(1);
    compare_all("t1");

    // Table vectors, one at a time.
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].num, vecs[i].den, vecs[i].tag);
      req_valid = 1'b0;
      exp_q.push_back('{q: vecs[i].q, tag: vecs[i].tag, dbz: 1'b0});
      wait_rsps(1);
      compare_all($sformatf("vec%0d", i));
    end

    // Six back-to-back pushes: FIFO fills after the fifth accept.
    @(posedge clk); #1 s0 = start_cnt;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      push(32'(1000 + 37 * i), 32'(i + 2), 4'(i));
      exp_q.push_back('{q: 32'((1000 + 37 * i) / (i + 2)), tag: 4'(i), dbz: 1'b0});
      if (i == 4) chk("t2_ready_full", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    wait_rsps(6);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 chk("t2_start_pulses", 32'(start_cnt - s0), 32'd6);
    @(negedge clk);
    compare_all("t2");

    // Back-pressure in HOLD: outputs stay put, nothing new issued.
    rdy_mode = 2;
    push(32'd1000, 32'd10, 4'd5);
    req_valid = 1'b0;
    for (int k = 0; k < 200 && !rsp_valid; k++) @(negedge clk);
    chk("t3_valid_seen", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t3_hold_quot", rsp_quotient, 32'd100);
      chk("t3_hold_tag", 32'(rsp_tag), 32'd5);
      chk("t3_hold_start", 32'(div_start), 32'd0);
    end
    rdy_mode = 0;
    exp_q.push_back('{q: 32'd100, tag: 4'd5, dbz: 1'b0});
    wait_rsps(1);
    compare_all("t3");

    // Divide by zero.
    @(posedge clk); #1 s0 = start_cnt;
    @(negedge clk);
    push(32'd5, 32'd0, 4'd9);
    req_valid = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
    chk("t4_valid_e1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("t4_valid_e2", 32'(rsp_valid), 32'd1);
    chk("t4_quot_e2", rsp_quotient, 32'hFFFF_FFFF);
    chk("t4_dbz_e2", 32'(rsp_dbz), 32'd1);
    exp_q.push_back('{q: 32'hFFFF_FFFF, tag: 4'd9, dbz: 1'b1});
    wait_rsps(1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 chk("t4_no_start", 32'(start_cnt - s0), 32'd0);
    @(negedge clk);
`else
    @(negedge clk);
    chk("t4_start_e2", 32'(div_start), 32'd1);
    exp_q.push_back('{q: 32'hFFFF_FFFF, tag: 4'd9, dbz: 1'b0});
    wait_rsps(1);
`endif
    compare_all("t4");

    // Reset while WAITing, then the divider's stale finish arrives.
    push(32'd900, 32'd3, 4'd6);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk); #1 f0 = fin_cnt;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid) hi_cnt++;
    end
    chk("t5_finish_seen", 32'(fin_cnt - f0), 32'd1);
    chk("t5_rsp_valid_cycles", 32'(hi_cnt), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd1);
    chk("t5_no_rsp", 32'(got_q.size()), 32'd0);
    got_q.delete();

    // Stream of 20 with random consumer back-pressure; pointers wrap several times.
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) begin
      n = $urandom;
      d = 32'($urandom_range(1, 1000));
      push(n, d, 4'(i));
      exp_q.push_back('{q: n / d, tag: 4'(i), dbz: 1'b0});
    end
    req_valid = 1'b0;
    wait_rsps(20);
    compare_all("t6");
    rdy_mode = 0;

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
